axi_write_monitor: RTL

Passive, parametrised AXI4 write-channel monitor. It is the successor to the plain write-channel tap, with configurable widths. It observes the AW, W and B handshakes without driving the bus and pairs each address with its data burst and response. For every completed write it emits one record on a valid/ready stream, keeps running counters, and flags protocol errors. It sits beside an AXI write port, for example a DMA or memory interface, as a debug and capture aid.

---
 rtl/axi_write_monitor_pkg.sv | 33 +++
 rtl/axi_write_monitor_sync_fifo.sv | 58 +++++
 rtl/axi_write_monitor.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_monitor_pkg.sv
// Shared types for the AXI write monitor: record layout, error bit positions and bresp encodings.
// Record id/addr fields are sized for the widest supported configuration and narrowed at the top.
package axi_write_monitor_pkg;

   localparam int MAX_ID_W   = 16;
   localparam int MAX_ADDR_W = 64;

   localparam int ERR_LEN    = 0;
   localparam int ERR_RESP   = 1;
   localparam int ERR_ID     = 2;
   localparam int ERR_ORPHAN = 3;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef struct packed {
      logic [MAX_ID_W-1:0]   id;
      logic [MAX_ADDR_W-1:0] addr;
      logic [7:0]            len;
      logic [8:0]            beats;
      resp_e                 resp;
      logic [3:0]            err;
   } rec_t;

   function automatic logic [8:0] expected_beats(input logic [7:0] len);
      return {1'b0, len} + 9'd1;
   endfunction

endpackage

// File: rtl/axi_write_monitor_sync_fifo.sv
// Synchronous FIFO, one-cycle write-to-read latency; push on full is dropped unless a pop happens
// in the same cycle. pop_dat shows the head entry combinationally while not empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_dat,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_en, rd_en;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_dat;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/axi_write_monitor.sv
// Passive AXI4 write monitor: pairs AW/W/B in order, record valid one cycle after B, held until rec_ready.
// Full FIFOs drop and set sticky overflow; AXI_WRITE_MONITOR_TIMEOUT_EN adds an AW-to-B watchdog.
module axi_write_monitor
   import axi_write_monitor_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 64,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_ID_WIDTH         = 4,
   parameter int C_DEPTH            = 16,
   parameter int C_CNT_WIDTH        = 32,
   parameter int C_TIMEOUT          = 1024
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic [C_ID_WIDTH-1:0]         s_axi_awid,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [7:0]                    s_axi_awlen,
   input  logic                          s_axi_awvalid,
   input  logic                          s_axi_awready,
   input  logic                          s_axi_wlast,
   input  logic                          s_axi_wvalid,
   input  logic                          s_axi_wready,
   input  logic [C_ID_WIDTH-1:0]         s_axi_bid,
   input  logic [1:0]                    s_axi_bresp,
   input  logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic                          clear,
   output logic                          rec_valid,
   input  logic                          rec_ready,
   output logic [C_ID_WIDTH-1:0]         rec_id,
   output logic [C_S_AXI_ADDR_WIDTH-1:0] rec_addr,
   output logic [7:0]                    rec_len,
   output logic [8:0]                    rec_beats,
   output logic [1:0]                    rec_resp,
   output logic [3:0]                    rec_err,
   output logic [C_CNT_WIDTH-1:0]        txn_count,
   output logic [C_CNT_WIDTH-1:0]        beat_count,
   output logic [C_CNT_WIDTH-1:0]        err_count,
   output logic                          overflow
);

   localparam int AW_W  = C_ID_WIDTH + C_S_AXI_ADDR_WIDTH + 8;
   localparam int REC_W = $bits(rec_t);

   logic                          aw_hs, w_hs, b_hs, to_fire;
   logic                          aw_full, aw_empty, aw_pop;
   logic                          w_full, w_empty, w_push;
   logic [AW_W-1:0]               aw_head;
   logic [8:0]                    w_head, w_beats;
   logic [8:0]                    beat_q, beat_d;
   logic [C_ID_WIDTH-1:0]         head_id;
   logic [C_S_AXI_ADDR_WIDTH-1:0] head_addr;
   logic [7:0]                    head_len;
   logic [8:0]                    head_beats;
   rec_t                          rec_in, rec_head;
   logic [REC_W-1:0]              rec_head_raw;
   logic                          rec_push, rec_pop, rec_full, rec_empty;
   logic [C_CNT_WIDTH-1:0]        txn_q, txn_d, beats_q, beats_d, errs_q, errs_d;
   logic                          ovf_q, ovf_d;

   assign aw_hs  = s_axi_awvalid & s_axi_awready;
   assign w_hs   = s_axi_wvalid & s_axi_wready;
   assign b_hs   = s_axi_bvalid & s_axi_bready;
   assign aw_pop = b_hs | to_fire;

   sync_fifo #(.WIDTH(AW_W), .DEPTH(C_DEPTH)) u_aw_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .push     (aw_hs),
      .push_dat ({s_axi_awid, s_axi_awaddr, s_axi_awlen}),
      .pop      (aw_pop),
      .pop_dat  (aw_head),
      .full     (aw_full),
      .empty    (aw_empty)
   );

   sync_fifo #(.WIDTH(9), .DEPTH(C_DEPTH)) u_w_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .push     (w_push),
      .push_dat (w_beats),
      .pop      (b_hs),
      .pop_dat  (w_head),
      .full     (w_full),
      .empty    (w_empty)
   );

   sync_fifo #(.WIDTH(REC_W), .DEPTH(C_DEPTH)) u_rec_fifo (
      .clk      (aclk),
      .rst_n    (aresetn),
      .push     (rec_push),
      .push_dat (rec_in),
      .pop      (rec_pop),
      .pop_dat  (rec_head_raw),
      .full     (rec_full),
      .empty    (rec_empty)
   );

`ifdef AXI_WRITE_MONITOR_TIMEOUT_EN
   localparam int WD_W = $clog2(C_TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   // A real B at the limit wins; its pop restarts the watchdog anyway.
   always_comb begin
      to_fire = !aw_empty && !b_hs && (wd_q == WD_W'(C_TIMEOUT - 1));
      wd_d    = wd_q + 1'b1;
      if (aw_empty || aw_pop) begin
         wd_d = '0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wd_q <= '0;
      end else begin
         wd_q <= wd_d;
      end
   end

   logic unused_cfg;
   assign unused_cfg = (C_S_AXI_DATA_WIDTH > 0);
`else
   assign to_fire = 1'b0;

   logic unused_cfg;
   assign unused_cfg = (C_S_AXI_DATA_WIDTH > 0) ^ (C_TIMEOUT > 0);
`endif

   always_comb begin
      w_beats = (beat_q == 9'd511) ? beat_q : beat_q + 9'd1;
      beat_d  = beat_q;
      w_push  = 1'b0;
      if (w_hs) begin
         if (s_axi_wlast) begin
            w_push = 1'b1;
            beat_d = '0;
         end else begin
            beat_d = w_beats;
         end
      end
   end

   always_comb begin
      head_id    = aw_empty ? '0 : aw_head[AW_W-1 -: C_ID_WIDTH];
      head_addr  = aw_empty ? '0 : aw_head[8 +: C_S_AXI_ADDR_WIDTH];
      head_len   = aw_empty ? '0 : aw_head[7:0];
      head_beats = w_empty ? '0 : w_head;

      rec_in      = '0;
      rec_in.id   = MAX_ID_W'(head_id);
      rec_in.addr = MAX_ADDR_W'(head_addr);
      rec_in.len  = head_len;
      if (b_hs) begin
         rec_in.beats           = head_beats;
         rec_in.resp            = resp_e'(s_axi_bresp);
         rec_in.err[ERR_ID]     = (s_axi_bid != head_id);
         rec_in.err[ERR_ORPHAN] = aw_empty | w_empty;
      end else begin
         rec_in.beats           = '0;
         rec_in.resp            = RESP_DECERR;
         rec_in.err[ERR_ORPHAN] = 1'b1;
      end
      rec_in.err[ERR_LEN]  = (rec_in.beats != expected_beats(head_len));
      rec_in.err[ERR_RESP] = (rec_in.resp != RESP_OKAY);
      rec_push             = b_hs | to_fire;
   end

   assign rec_valid = ~rec_empty;
   assign rec_pop   = rec_valid & rec_ready;
   assign rec_head  = rec_t'(rec_head_raw);

   always_comb begin
      txn_d   = txn_q;
      beats_d = beats_q;
      errs_d  = errs_q;
      ovf_d   = ovf_q;
      if (b_hs) begin
         txn_d = txn_q + 1'b1;
      end
      if (w_hs) begin
         beats_d = beats_q + 1'b1;
      end
      if (rec_push && (rec_in.err != '0)) begin
         errs_d = errs_q + 1'b1;
      end
      // The FIFO accepts a push on full only when it is popped in the same cycle.
      if ((aw_hs && aw_full && !aw_pop) || (w_push && w_full && !b_hs) ||
          (rec_push && rec_full && !rec_pop)) begin
         ovf_d = 1'b1;
      end
      if (clear) begin
         txn_d   = '0;
         beats_d = '0;
         errs_d  = '0;
         ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         beat_q  <= '0;
         txn_q   <= '0;
         beats_q <= '0;
         errs_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         beat_q  <= beat_d;
         txn_q   <= txn_d;
         beats_q <= beats_d;
         errs_q  <= errs_d;
         ovf_q   <= ovf_d;
      end
   end

   assign rec_id     = rec_valid ? rec_head.id[C_ID_WIDTH-1:0] : '0;
   assign rec_addr   = rec_valid ? rec_head.addr[C_S_AXI_ADDR_WIDTH-1:0] : '0;
   assign rec_len    = rec_valid ? rec_head.len : '0;
   assign rec_beats  = rec_valid ? rec_head.beats : '0;
   assign rec_resp   = rec_valid ? rec_head.resp : '0;
   assign rec_err    = rec_valid ? rec_head.err : '0;
   assign txn_count  = txn_q;
   assign beat_count = beats_q;
   assign err_count  = errs_q;
   assign overflow   = ovf_q;

   logic unused_rec;
   assign unused_rec = ^{rec_head.id, rec_head.addr};

endmodule
